msr_reader: RTL
===============

# msr_reader

Initiator end of the measurement-transfer handshake: drives `data_req`, waits for the responder's `data_rdy`, captures the 24-bit `msr_data` timestamp, and presents it with the modulo-2^24 difference from the previous capture. Sits in the same clock domain fabric as a logic-side consumer (period/jitter measurement, loopback test of the GPIO timestamp path). `data_rdy` and `msr_data` arrive from an asynchronous responder and are treated as asynchronous.

## Interface
Parameters:
- `MSR_W`, 24: timestamp width; all arithmetic modulo 2^MSR_W.
- `SYNC_STAGES`, 2: flops in the `data_rdy` synchronizer (min 2).
- `TIMEOUT_CYCLES`, 1024: max cycles waited in each handshake phase (min 2).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request one measurement; sampled only in IDLE.
- `data_rdy` in 1: responder ready, asynchronous.
- `msr_data` in MSR_W: responder timestamp, stable while synchronized `data_rdy` is high.
- `data_req` out 1: request to responder (registered).
- `busy` out 1: high in any state other than IDLE.
- `sample` out MSR_W: last captured timestamp.
- `delta` out MSR_W: `sample` minus previous `sample`, modulo 2^MSR_W.
- `sample_valid` out 1: one-cycle pulse when `sample`/`delta` update.
- `timeout_err` out 1: one-cycle pulse on a handshake timeout.

## Operation
- FSM states: IDLE, REQ, RELEASE.
- IDLE: `data_req`=0. `start`=1 -> REQ, `data_req`=1 next cycle, timeout counter cleared.
- REQ: wait for synchronized `rdy_s`=1. On it: capture `msr_data` into `sample`, update `delta`, pulse `sample_valid`, drop `data_req`, -> RELEASE.
- RELEASE: `data_req`=0; wait for `rdy_s`=0 -> IDLE.
- Timeout: per-phase counter increments each cycle in REQ/RELEASE. At TIMEOUT_CYCLES-1 without exit condition: pulse `timeout_err`. In REQ, go to RELEASE without capture. In RELEASE, go to IDLE.
- `start` outside IDLE is ignored (not queued).
- Delta: `delta = msr_data - sample_prev` in MSR_W bits, wrap-around intentional (0x000005 - 0xFFFFFE = 0x000007). The first capture after reset gives `delta`=0. A capture after a timed-out REQ uses the last good sample as previous.
- Reset values: `data_req`=0, `busy`=0, `sample`=0, `delta`=0, `sample_valid`=0, `timeout_err`=0, synchronizer flops 0, state IDLE, first-capture flag set.
- Reset mid-handshake: `data_req` drops immediately (asynchronous). The responder sees a normal release.

## Timing
- `start` at cycle N -> `data_req`=1 at N+1.
- `data_rdy` rising -> `rdy_s` high after SYNC_STAGES edges. Capture, `sample_valid` pulse and `data_req` fall happen on the same edge, one cycle after `rdy_s` is seen high.
- `msr_data` is sampled only in that capture cycle. Its stability is guaranteed by the protocol: the responder latches before raising `data_rdy`.
- Minimum transaction is about 2*SYNC_STAGES + responder latency + 3 cycles. Back-to-back `start` is accepted on the first IDLE cycle.
- `timeout_err` and `sample_valid` are never high in the same cycle.

## Configuration
- `MSR_READER_DELTA_EN` defined: delta subtractor, previous-sample register and first-capture flag present, behaving as above.
- Not defined: `delta` tied to 0. `sample`, `sample_valid` and handshake behaviour are unchanged.

## Structure
- Shared package `msr_pkg`:
  - state enum `msr_rd_state_t` (IDLE, REQ, RELEASE)
  - default `MSR_W` = 24 constant, shared with the responder
- One sub-module: `msr_sync`, a SYNC_STAGES-deep single-bit synchronizer with async reset to 0, used for `data_rdy`.

## Test plan
- Responder model with 3-cycle latency, `msr_data`=0x000100: `start` pulse -> `data_req` high next cycle; `sample`=0x000100 and `sample_valid` pulse; `delta`=0; `data_req` low in the capture cycle; `busy` low after `rdy` drops.
- Two transactions with captures 0x000100 then 0x000164 -> second `delta`=0x000064.
- Wrap: captures 0xFFFFFE then 0x000005 -> `delta`=0x000007.
- Responder never raises `data_rdy`, TIMEOUT_CYCLES=16 -> `timeout_err` pulse 15 cycles after entering REQ; no `sample_valid`; returns to IDLE once `rdy` is low.
- `start` held high throughout plus a second `start` while busy -> exactly one transaction per IDLE visit; `rst` asserted mid-REQ -> `data_req`=0 immediately and all outputs at reset values.
- Build without `MSR_READER_DELTA_EN` -> `delta` stays 0 across the wrap scenario; `sample` values identical to the first build.

Source files
------------

// File: rtl/msr_pkg.sv
// -----------------------------------------------------------------------------
// msr_pkg
// Shared definitions for the measurement-transfer handshake. The responder and
// the initiator (msr_reader) both pull the default timestamp width from here.
// Contents:
//   MSR_W_DEFAULT  - default timestamp width (24 bits)
//   msr_rd_state_t - initiator FSM states (IDLE, REQ, RELEASE)
// -----------------------------------------------------------------------------
package msr_pkg;

    localparam int MSR_W_DEFAULT = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } msr_rd_state_t;

endpackage : msr_pkg

// File: rtl/msr_sync.sv
// -----------------------------------------------------------------------------
// msr_sync
// Single-bit multi-flop synchronizer for an asynchronous level input.
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears every stage to 0
//   d   - asynchronous input level
//   q   - synchronized level, STAGES rising edges behind d
// Parameters:
//   STAGES - number of flops in the chain (2 or more)
// -----------------------------------------------------------------------------
module msr_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Stage 0 is the only flop that may go metastable; the rest give it
    // time to resolve before anything downstream looks at the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q[0] <= 1'b0;
        end else begin
            sync_q[0] <= d;
        end
    end

    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q[gi] <= 1'b0;
            end else begin
                sync_q[gi] <= sync_q[gi-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : msr_sync

// File: rtl/msr_reader.sv
// -----------------------------------------------------------------------------
// msr_reader
// Initiator side of the measurement-transfer handshake. Raises data_req, waits
// for the (asynchronous) responder's data_rdy, captures the msr_data timestamp
// and reports it together with the modulo-2^MSR_W difference from the previous
// good capture. Each handshake phase is guarded by a timeout.
//
// Ports:
//   clk          - clock, all logic on the rising edge
//   rst          - asynchronous active-high reset
//   start        - request one measurement (only looked at in IDLE)
//   data_rdy     - responder ready, asynchronous (synchronized internally)
//   msr_data     - responder timestamp, stable while data_rdy is high
//   data_req     - registered request to the responder
//   busy         - high whenever the FSM is not in IDLE
//   sample       - last captured timestamp
//   delta        - sample minus previous sample, modulo 2^MSR_W
//   sample_valid - one-cycle pulse when sample/delta update
//   timeout_err  - one-cycle pulse when a handshake phase times out
//
// Build option:
//   MSR_READER_DELTA_EN - when defined, the delta subtractor and first-capture
//                         flag are built; otherwise delta is tied to zero.
// -----------------------------------------------------------------------------
module msr_reader
    import msr_pkg::*;
#(
    parameter int MSR_W          = MSR_W_DEFAULT,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             data_rdy,
    input  logic [MSR_W-1:0] msr_data,
    output logic             data_req,
    output logic             busy,
    output logic [MSR_W-1:0] sample,
    output logic [MSR_W-1:0] delta,
    output logic             sample_valid,
    output logic             timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // The counter is 0 in the first cycle of a phase; the timeout fires on the
    // edge where it would reach TIMEOUT_CYCLES-1, so the error pulse lands
    // TIMEOUT_CYCLES-1 cycles after the phase was entered.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    msr_rd_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_req_q, data_req_d;
    logic [MSR_W-1:0] sample_q, sample_d;
    logic             sample_valid_q, sample_valid_d;
    logic             timeout_q, timeout_d;
    logic             rdy_s;

    msr_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rdy_sync (
        .clk (clk),
        .rst (rst),
        .d   (data_rdy),
        .q   (rdy_s)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        data_req_d     = data_req_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        timeout_d      = 1'b0;

        case (state_q)
            IDLE: begin
                data_req_d = 1'b0;
                if (start) begin
                    state_d    = REQ;
                    data_req_d = 1'b1;
                    cnt_d      = '0;
                end
            end

            REQ: begin
                if (rdy_s) begin
                    // msr_data is only looked at here; the responder latched
                    // it before raising data_rdy, so it is settled by now.
                    sample_d       = msr_data;
                    sample_valid_d = 1'b1;
                    data_req_d     = 1'b0;
                    state_d        = RELEASE;
                    cnt_d          = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Give up on this request but still walk through RELEASE
                    // so a late data_rdy is seen to drop before the next start.
                    timeout_d  = 1'b1;
                    data_req_d = 1'b0;
                    state_d    = RELEASE;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RELEASE: begin
                data_req_d = 1'b0;
                if (!rdy_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d    = IDLE;
                data_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            data_req_q     <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            data_req_q     <= data_req_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            timeout_q      <= timeout_d;
        end
    end

`ifdef MSR_READER_DELTA_EN
    // sample_q only changes on a good capture, so it already holds the
    // previous good sample when the next capture happens; timed-out requests
    // leave it untouched.
    logic             first_q, first_d;
    logic [MSR_W-1:0] delta_q, delta_d;
    logic             capture;

    assign capture = (state_q == REQ) && rdy_s;

    always_comb begin
        first_d = first_q;
        delta_d = delta_q;
        if (capture) begin
            first_d = 1'b0;
            delta_d = first_q ? '0 : (msr_data - sample_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= 1'b1;
            delta_q <= '0;
        end else begin
            first_q <= first_d;
            delta_q <= delta_d;
        end
    end

    assign delta = delta_q;
`else
    assign delta = '0;
`endif

    assign data_req     = data_req_q;
    assign busy         = (state_q != IDLE);
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign timeout_err  = timeout_q;

endmodule : msr_reader
